// File: rtl/vrb_dmem_slave.sv
// VRB data-memory responder: byte-masked word memory with a fixed LAT-stage response pipeline.
// Optional bus-error checking (out-of-range / misaligned) is enabled by defining VRB_DMEM_BUSERR_EN.
module vrb_dmem_slave #(
  parameter int            AW    = 32,
  parameter int            DW    = 32,
  parameter int            DEPTH = 1024,
  parameter logic [AW-1:0] BASE  = 32'h8000_0000,
  parameter int            LAT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_vrb_cmd_valid,
  input  logic [AW-1:0]   i_vrb_cmd_addr,
  input  logic            i_vrb_cmd_read,
  input  logic [DW-1:0]   i_vrb_cmd_wdata,
  input  logic [DW/8-1:0] i_vrb_cmd_wmask,
  output logic            o_vrb_rsp_valid,
  output logic            o_vrb_rsp_err,
  output logic [DW-1:0]   o_vrb_rsp_rdata
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0] offset_s;
  logic [IW-1:0] idx_s;
  logic          in_range_s;
  logic          err_s;
  logic          wr_en_s;

  logic [DW-1:0] mem_q [DEPTH];

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] err_q;
  logic [DW-1:0]  rdata_q [LAT];
  logic           vld_d;
  logic           err_d;
  logic [DW-1:0]  rdata_d;

`ifdef VRB_DMEM_BUSERR_EN
  // A write mask is well-formed when its set bits form at most one run.
  function automatic logic mask_contig(input logic [NB-1:0] m);
    int   runs;
    logic prev;
    runs = 0;
    prev = 1'b0;
    for (int n = 0; n < NB; n++) begin
      if (m[n] && !prev) begin
        runs = runs + 1;
      end
      prev = m[n];
    end
    return (runs <= 1);
  endfunction
`endif

  assign offset_s   = i_vrb_cmd_addr - BASE;
  assign idx_s      = offset_s[OW +: IW];
  assign in_range_s = ((offset_s >> (IW + OW)) == {AW{1'b0}});

  // Access classification for the incoming command.
  always_comb begin
    err_s = 1'b0;
`ifdef VRB_DMEM_BUSERR_EN
    if (!in_range_s) begin
      err_s = 1'b1;
    end else if (i_vrb_cmd_read) begin
      err_s = (offset_s[OW-1:0] != {OW{1'b0}});
    end else begin
      err_s = !mask_contig(i_vrb_cmd_wmask);
    end
`else
    err_s = 1'b0;
`endif
  end

`ifndef VRB_DMEM_BUSERR_EN
  logic unused_in_range_s;
  assign unused_in_range_s = in_range_s;
`endif

  assign wr_en_s = i_vrb_cmd_valid && !i_vrb_cmd_read && !err_s;

  // Byte-lane write port; the array is intentionally outside reset so contents survive it.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NB; n++) begin
      if (wr_en_s && i_vrb_cmd_wmask[n]) begin
        mem_q[idx_s][8*n +: 8] <= i_vrb_cmd_wdata[8*n +: 8];
      end
    end
  end

  // First response stage: read data is the pre-edge word, zero for writes and errors.
  always_comb begin
    vld_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = {DW{1'b0}};
    if (i_vrb_cmd_valid) begin
      vld_d = 1'b1;
      err_d = err_s;
      if (i_vrb_cmd_read && !err_s) begin
        rdata_d = mem_q[idx_s];
      end else begin
        rdata_d = {DW{1'b0}};
      end
    end else begin
      vld_d   = 1'b0;
      err_d   = 1'b0;
      rdata_d = {DW{1'b0}};
    end
  end

  // Response pipeline: free-running shift, reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= {LAT{1'b0}};
      err_q <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        rdata_q[i] <= {DW{1'b0}};
      end
    end else begin
      vld_q[0]   <= vld_d;
      err_q[0]   <= err_d;
      rdata_q[0] <= rdata_d;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]   <= vld_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign o_vrb_rsp_valid = vld_q[LAT-1];
  assign o_vrb_rsp_err   = err_q[LAT-1];
  assign o_vrb_rsp_rdata = rdata_q[LAT-1];

endmodule

// File: tb/tb_vrb_dmem_slave.sv
// Scoreboard bench for vrb_dmem_slave: one LAT=1 and one LAT=3 instance fed the same commands.
// Expectations for the decode test depend on VRB_DMEM_BUSERR_EN.
module tb_vrb_dmem_slave;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst1;
  logic        rst3;
  logic        valid;
  logic [31:0] addr;
  logic        rd;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        v1, e1, v3, e3;
  logic [31:0] d1, d3;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t x1, x3;

  vrb_dmem_slave #(.LAT(LAT_A)) dut1 (
    .clk(clk), .rst(rst1),
    .i_vrb_cmd_valid(valid), .i_vrb_cmd_addr(addr), .i_vrb_cmd_read(rd),
    .i_vrb_cmd_wdata(wdata), .i_vrb_cmd_wmask(wmask),
    .o_vrb_rsp_valid(v1), .o_vrb_rsp_err(e1), .o_vrb_rsp_rdata(d1)
  );

  vrb_dmem_slave #(.LAT(LAT_B)) dut3 (
    .clk(clk), .rst(rst3),
    .i_vrb_cmd_valid(valid), .i_vrb_cmd_addr(addr), .i_vrb_cmd_read(rd),
    .i_vrb_cmd_wdata(wdata), .i_vrb_cmd_wmask(wmask),
    .o_vrb_rsp_valid(v3), .o_vrb_rsp_err(e3), .o_vrb_rsp_rdata(d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard for the LAT=1 instance; latency is checked through the expected cycle.
  always @(negedge clk) begin
    if (v1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rsp_lat1_unexpected: valid at cycle %0d, required no response", cyc);
      end else begin
        x1 = q1.pop_front();
        if (e1 !== x1.err || d1 !== x1.rdata || cyc != x1.cyc) begin
          errors++;
          $display("FAIL rsp_lat1: err=%0b rdata=%h cycle=%0d, required err=%0b rdata=%h cycle=%0d",
                   e1, d1, cyc, x1.err, x1.rdata, x1.cyc);
        end
      end
    end
  end

  // Scoreboard for the LAT=3 instance.
  always @(negedge clk) begin
    if (v3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL rsp_lat3_unexpected: valid at cycle %0d, required no response", cyc);
      end else begin
        x3 = q3.pop_front();
        if (e3 !== x3.err || d3 !== x3.rdata || cyc != x3.cyc) begin
          errors++;
          $display("FAIL rsp_lat3: err=%0b rdata=%h cycle=%0d, required err=%0b rdata=%h cycle=%0d",
                   e3, d3, cyc, x3.err, x3.rdata, x3.cyc);
        end
      end
    end
  end

  task automatic cmd(input logic [31:0] a, input logic r, input logic [31:0] wd,
                     input logic [3:0] wm, input logic x_err, input logic [31:0] x_rdata);
    @(negedge clk);
    valid = 1'b1;
    addr  = a;
    rd    = r;
    wdata = wd;
    wmask = wm;
    q1.push_back('{err: x_err, rdata: x_rdata, cyc: cyc + LAT_A});
    q3.push_back('{err: x_err, rdata: x_rdata, cyc: cyc + LAT_B});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      rd    = 1'b0;
      wmask = 4'h0;
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    rst3 = 1'b1;
    valid = 1'b0;
    addr = 32'h0;
    rd = 1'b0;
    wdata = 32'h0;
    wmask = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({v1, e1, d1} !== 34'h0) begin
      errors++;
      $display("FAIL reset_lat1: valid=%0b err=%0b rdata=%h, required all 0", v1, e1, d1);
    end
    checks++;
    if ({v3, e3, d3} !== 34'h0) begin
      errors++;
      $display("FAIL reset_lat3: valid=%0b err=%0b rdata=%h, required all 0", v3, e3, d3);
    end
    rst1 = 1'b0;
    rst3 = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    cmd(32'h8000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    cmd(32'h8000_0010, 1'b1, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF);
    idle(5);
  endtask

  task automatic test_byte_mask();
    cmd(32'h8000_0020, 1'b0, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
`ifdef VRB_DMEM_BUSERR_EN
    cmd(32'h8000_0020, 1'b0, 32'hAABB_CCDD, 4'h5, 1'b1, 32'h0);
    cmd(32'h8000_0020, 1'b1, 32'h0,         4'hF, 1'b0, 32'h1122_3344);
`else
    cmd(32'h8000_0020, 1'b0, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0);
    cmd(32'h8000_0020, 1'b1, 32'h0,         4'hF, 1'b0, 32'h11BB_33DD);
`endif
    idle(5);
  endtask

  task automatic test_wmask_zero();
    cmd(32'h8000_0040, 1'b0, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0);
    cmd(32'h8000_0040, 1'b0, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0);
    cmd(32'h8000_0040, 1'b1, 32'h0,         4'h0, 1'b0, 32'hCAFE_F00D);
    idle(5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      cmd(32'h8000_0100 + 32'(4 * i), 1'b0, 32'hC0DE_0000 + 32'(i * 257), 4'hF, 1'b0, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      cmd(32'h8000_0100 + 32'(4 * i), 1'b1, 32'h0, 4'h0, 1'b0, 32'hC0DE_0000 + 32'(i * 257));
    end
    idle(6);
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: pending lat1=%0d lat3=%0d, required 0 and 0", q1.size(), q3.size());
    end
  endtask

  task automatic test_reset_midflight();
    cmd(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    valid = 1'b0;
    rst3  = 1'b1;
    q3.delete();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({v3, e3, d3} !== 34'h0) begin
        errors++;
        $display("FAIL midreset_outputs[%0d]: valid=%0b err=%0b rdata=%h, required all 0", k, v3, e3, d3);
      end
      @(negedge clk);
    end
    rst3 = 1'b0;
    idle(6);
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL midreset_lat1_drain: pending=%0d, required 0", q1.size());
    end
    cmd(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
    idle(5);
  endtask

  task automatic test_decode();
`ifdef VRB_DMEM_BUSERR_EN
    cmd(32'h8000_0000, 1'b0, 32'h0BAD_CAFE, 4'hF, 1'b0, 32'h0);
    cmd(32'h7FFF_FFFC, 1'b0, 32'h1234_5678, 4'hF, 1'b1, 32'h0);
    cmd(32'h8000_1000, 1'b0, 32'h1234_5678, 4'hF, 1'b1, 32'h0);
    cmd(32'h8000_0000, 1'b0, 32'h5555_5555, 4'h9, 1'b1, 32'h0);
    cmd(32'h8000_0002, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0);
    cmd(32'h8000_0000, 1'b1, 32'h0,         4'h0, 1'b0, 32'h0BAD_CAFE);
    cmd(32'h8000_0000, 1'b0, 32'h00FF_EE00, 4'h6, 1'b0, 32'h0);
    cmd(32'h8000_0000, 1'b1, 32'h0,         4'h0, 1'b0, 32'h0BFF_EEFE);
`else
    cmd(32'h8000_1000, 1'b0, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
    cmd(32'h8000_0000, 1'b1, 32'h0,         4'h0, 1'b0, 32'h1234_5678);
    cmd(32'h8000_0002, 1'b1, 32'h0,         4'h0, 1'b0, 32'h1234_5678);
    cmd(32'h7FFF_FFFC, 1'b0, 32'hFEED_FACE, 4'hF, 1'b0, 32'h0);
    cmd(32'h8000_0FFC, 1'b1, 32'h0,         4'h0, 1'b0, 32'hFEED_FACE);
`endif
    idle(6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_mask();
    test_wmask_zero();
    test_back_to_back();
    test_reset_midflight();
    test_decode();
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL final_drain: pending lat1=%0d lat3=%0d, required 0 and 0", q1.size(), q3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vrb_dmem_slave.md
Name: vrb_dmem_slave

Overview:
- VRB responder (slave) for the LSU master port: accepts the same cmd fields (valid/addr/read/wdata/wmask) and returns rsp valid/err/rdata.
- Backs a word-organised data memory of DEPTH words located at BASE.
- Returns exactly one response per accepted command, after a fixed LAT-cycle pipeline.
- Sits between the core's data-side VRB and the data memory map. It is the load/store target for exeu's LSU.

Parameters:
AW, 32, address width
DW, 32, data width; DW/8 byte lanes
DEPTH, 1024, memory depth in DW-bit words; power of two, >= 2
BASE, 32'h8000_0000, byte base address; aligned to DEPTH*DW/8
LAT, 1, response latency in cycles; legal 1..4

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
i_vrb_cmd_valid  input  1  command present this cycle; always accepted (protocol has no ready)
i_vrb_cmd_addr  input  AW  byte address
i_vrb_cmd_read  input  1  1 = read, 0 = write
i_vrb_cmd_wdata  input  DW  write data, lane-aligned
i_vrb_cmd_wmask  input  DW/8  byte write enables, bit n -> wdata[8n+7:8n]
o_vrb_rsp_valid  output  1  response valid, one-cycle pulse per command
o_vrb_rsp_err  output  1  response error; qualified by o_vrb_rsp_valid
o_vrb_rsp_rdata  output  DW  read data; 0 for writes and errored accesses

Behaviour:
- Reset (async assert, sync release):
  - o_vrb_rsp_valid=0, o_vrb_rsp_err=0, o_vrb_rsp_rdata=0.
  - All LAT response-pipeline stages cleared.
  - Memory array is NOT reset; contents are retained.
- Reset mid-operation: in-flight responses are dropped with no rsp pulse. Writes already committed stay in memory.
- Accept: every clk edge with i_vrb_cmd_valid=1 is one command. Back-to-back commands every cycle are allowed.
- Address decode:
  - offset = addr - BASE, computed mod 2^AW.
  - word index = offset[log2(DEPTH)+1:2].
  - in_range = offset < DEPTH*DW/8.
- Write (read=0), legal access:
  - At the accept edge, memory[idx] byte n <= wdata byte n for each wmask[n]=1. Other bytes unchanged.
  - wmask=0 is legal: no change, normal response.
- Read (read=1), legal access: rdata = memory[idx] as it was before the accept edge. wmask is ignored.
- Same-cycle ordering:
  - Only one command per cycle, so there are no same-cycle read/write conflicts.
  - A write at cycle t followed by a read of the same word at t+1 returns the new data.
- Response timing:
  - Command accepted at edge t produces rsp_valid=1 for exactly the cycle after edge t+LAT-1.
  - With LAT=1, the response is registered and visible the cycle after the accept.
  - Responses return strictly in command order; no reordering.
- Response pipeline: LAT stages of {valid, err, rdata}, shifted every cycle unconditionally. There is no backpressure, so the master must accept every response.
- Outputs come directly from the last pipeline stage; there is no combinational path from cmd to rsp.

Optional Feature:
- Macro: VRB_DMEM_BUSERR_EN.
- Defined:
  - A command is errored if in_range=0, or if the access is misaligned.
  - Misaligned = set wmask bits not contiguous inside the word on a write, or addr[1:0] != 0 on a read.
  - Errored writes do not modify memory.
  - Errored responses carry err=1 and rdata=0, with the same latency as legal responses.
- Undefined:
  - err is tied to 0.
  - Address aliases modulo DEPTH words (in_range ignored, addr[1:0] ignored).
  - Every write commits per wmask.

Test Plan:
- LAT=1: write addr=0x8000_0010, wdata=0xDEAD_BEEF, wmask=0xF; next cycle read 0x8000_0010 -> rsp one cycle after each cmd; read rsp rdata=0xDEAD_BEEF, err=0; write rsp rdata=0.
- Byte mask: preload 0x1122_3344 at 0x8000_0020; write wdata=0xAABB_CCDD, wmask=0x5; read back -> 0x11BB_33DD.
- Streaming, LAT=3: 8 back-to-back reads of consecutive words -> 8 consecutive rsp_valid cycles starting 3 cycles after the first cmd, in order, with correct data.
- Reset mid-flight, LAT=3: issue a read, assert rst 1 cycle later -> outputs 0 immediately; no rsp after release; memory contents unchanged on re-read.
- BUSERR_EN defined: write 0x1234_5678 to 0x7FFF_FFFC -> err=1; read of 0x8000_0002 -> err=1, rdata=0. Without the macro: write to BASE+DEPTH*4 aliases to word 0, and a read of BASE returns 0x1234_5678-style aliased data with err=0.
- Write-only stream: wmask=0 write to a word holding 0xCAFE_F00D -> rsp err=0; subsequent read returns 0xCAFE_F00D.
